// File: rtl/seg7_mux.sv
// Multiplexed 1..8 digit 7-segment driver with PWM brightness and raw mode.
// Define SEG7_READBACK_EN to enable registered register readback on d_out.
module seg7_mux #(
    parameter logic [31:0] BASE     = 32'h10,
    parameter int          NDIGITS  = 4,
    parameter int          PRESCALE = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               rw,
    input  logic [31:0]        addr,
    input  logic [31:0]        data,
    output logic [31:0]        d_out,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int NW = 4 * NDIGITS;

    logic              in_range;
    logic              wr_en;
    logic [31:0]       rel;
    logic [1:0]        offset;
    logic              sel_data;
    logic              sel_dp;
    logic              sel_ctrl;
    logic              sel_raw;
    logic              raw_ok;

    logic [NW-1:0]      data_r;
    logic [NDIGITS-1:0] dp_r;
    logic [NDIGITS-1:0] blank_r;
    logic [NDIGITS-1:0] rawm_r;
    logic [3:0]         bright_r;
    logic [6:0]         raw_r [NDIGITS];

    logic [PW-1:0]      presc;
    logic [3:0]         phase;
    logic [DW-1:0]      digit;
    logic               tick;

    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_blank;
    logic               cur_rawm;
    logic [6:0]         cur_pat;
    logic               lit;
    logic [7:0]         seg_nxt;
    logic [NDIGITS-1:0] an_nxt;

    logic               unused;

    assign in_range = (addr >= BASE) && (addr < BASE + 32'd4);
    assign wr_en    = enable && rw && in_range;
    assign rel      = addr - BASE;
    assign offset   = rel[1:0];
    assign sel_data = (offset == 2'd0);
    assign sel_dp   = (offset == 2'd1);
    assign sel_ctrl = (offset == 2'd2);
    assign sel_raw  = (offset == 2'd3);
    assign raw_ok   = 32'(data[10:8]) < 32'(NDIGITS);
    assign unused   = ^{data, rel};

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0:    font = 7'h3F;
            4'h1:    font = 7'h06;
            4'h2:    font = 7'h5B;
            4'h3:    font = 7'h4F;
            4'h4:    font = 7'h66;
            4'h5:    font = 7'h6D;
            4'h6:    font = 7'h7D;
            4'h7:    font = 7'h07;
            4'h8:    font = 7'h7F;
            4'h9:    font = 7'h6F;
            4'hA:    font = 7'h77;
            4'hB:    font = 7'h7C;
            4'hC:    font = 7'h39;
            4'hD:    font = 7'h5E;
            4'hE:    font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r   <= '0;
            dp_r     <= '0;
            blank_r  <= '0;
            rawm_r   <= '0;
            bright_r <= 4'hF;
            for (int i = 0; i < NDIGITS; i++) raw_r[i] <= '0;
        end else if (wr_en) begin
            unique case (1'b1)
                sel_data: data_r <= data[NW-1:0];
                sel_dp:   dp_r   <= data[NDIGITS-1:0];
                sel_ctrl: begin
                    blank_r  <= data[NDIGITS-1:0];
                    rawm_r   <= data[8 +: NDIGITS];
                    bright_r <= data[19:16];
                end
                sel_raw: begin
                    for (int i = 0; i < NDIGITS; i++)
                        if (raw_ok && data[10:8] == 3'(i))
                            raw_r[i] <= data[6:0];
                end
                default: ;
            endcase
        end
    end

    // Scan chain: prescaler -> 16-step PWM phase -> digit index
    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= '0;
            digit <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                phase <= phase + 4'd1;
                if (phase == 4'hF)
                    digit <= (digit == DW'(NDIGITS - 1)) ? '0 : digit + 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_rawm  = 1'b0;
        cur_pat   = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (digit == DW'(i)) begin
                cur_nib   = data_r[4*i +: 4];
                cur_dp    = dp_r[i];
                cur_blank = blank_r[i];
                cur_rawm  = rawm_r[i];
                cur_pat   = raw_r[i];
            end
        end
    end

    // Phase 0 is a dark guard slot so the previous digit cannot ghost
    always_comb begin
        lit     = (phase != 4'd0) && (phase <= bright_r) && !cur_blank;
        seg_nxt = 8'hFF;
        an_nxt  = '1;
        if (lit) begin
            seg_nxt = {~cur_dp, ~(cur_rawm ? cur_pat : font(cur_nib))};
            for (int i = 0; i < NDIGITS; i++)
                if (digit == DW'(i)) an_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

`ifdef SEG7_READBACK_EN
    logic [2:0]  last_idx;
    logic [31:0] rd_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_idx <= '0;
        else if (wr_en && sel_raw && raw_ok)
            last_idx <= data[10:8];
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_data: rd_val[NW-1:0] = data_r;
            sel_dp:   rd_val[NDIGITS-1:0] = dp_r;
            sel_ctrl: begin
                rd_val[NDIGITS-1:0] = blank_r;
                rd_val[8 +: NDIGITS] = rawm_r;
                rd_val[19:16] = bright_r;
            end
            sel_raw: begin
                rd_val[10:8] = last_idx;
                for (int i = 0; i < NDIGITS; i++)
                    if (last_idx == 3'(i)) rd_val[6:0] = raw_r[i];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            d_out <= '0;
        else
            d_out <= (enable && !rw && in_range) ? rd_val : '0;
    end
`else
    assign d_out = '0;
`endif

endmodule

// File: tb/tb_seg7_mux.sv
// Scoreboard bench for seg7_mux: expected pin values are derived from
// elapsed cycles since reset and a shadow copy of the written registers.
module tb_seg7_mux;

    localparam int          P    = 2;
    localparam int          ND   = 4;
    localparam logic [31:0] BASE = 32'h10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [31:0] d_out;
    logic [7:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg7_mux #(
        .BASE(BASE),
        .NDIGITS(ND),
        .PRESCALE(P)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .rw(rw),
        .addr(addr),
        .data(data),
        .d_out(d_out),
        .seg(seg),
        .an(an)
    );

    int cyc;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] sh_data;
    logic [3:0]  sh_dp, sh_blank, sh_rawm, sh_bright;
    logic [6:0]  sh_raw [4];
    logic [2:0]  sh_last;

    logic [11:0] q  [$];
    logic [31:0] rq [$];

    logic [6:0] font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic reset_shadow();
        sh_data = '0; sh_dp = '0; sh_blank = '0; sh_rawm = '0;
        sh_bright = 4'hF; sh_last = '0;
        for (int i = 0; i < 4; i++) sh_raw[i] = '0;
    endtask

    function automatic logic [11:0] exp_pins(int t);
        int ph, d;
        logic [3:0] a;
        logic [7:0] s;
        logic [6:0] pat;
        ph = (t / P) % 16;
        d  = (t / (16 * P)) % ND;
        a = 4'hF;
        s = 8'hFF;
        if (ph != 0 && ph <= int'(sh_bright) && !sh_blank[d]) begin
            pat = sh_rawm[d] ? sh_raw[d] : font[sh_data[4*d +: 4]];
            a[d] = 1'b0;
            s = {~sh_dp[d], ~pat};
        end
        return {a, s};
    endfunction

    task automatic push_expected(int n);
        int k0;
        k0 = cyc;
        for (int i = 0; i < n; i++) q.push_back(exp_pins(k0 + i));
    endtask

    task automatic bus_write(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        enable = 1'b1; rw = 1'b1; addr = a; data = d;
        @(negedge clk);
        enable = 1'b0; rw = 1'b0;
        if (a >= BASE && a < BASE + 4) begin
            case (a - BASE)
                0: sh_data = d[15:0];
                1: sh_dp = d[3:0];
                2: begin
                    sh_blank = d[3:0]; sh_rawm = d[11:8];
                    sh_bright = d[19:16];
                end
                default: if (d[10:8] < 4) begin
                    sh_raw[d[9:8]] = d[6:0];
                    sh_last = d[10:8];
                end
            endcase
        end
    endtask

    task automatic test_reset();
        logic [11:0] e;
        int first_lit;
        reset_shadow();
        #12;
        n_checks++;
        if (seg !== 8'hFF) begin
            n_fail++; $display("FAIL reset_seg got %h want ff", seg);
        end
        n_checks++;
        if (an !== 4'hF) begin
            n_fail++; $display("FAIL reset_an got %b want 1111", an);
        end
        n_checks++;
        if (d_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_dout got %h want 0", d_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        first_lit = -1;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL reset_scan cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            if (first_lit < 0 && an != 4'hF) first_lit = i + 1;
        end
        n_checks++;
        if (first_lit !== 3) begin
            n_fail++; $display("FAIL reset_first_lit got %0d want 3", first_lit);
        end
    endtask

    task automatic test_hex_scan();
        logic [11:0] e;
        int lo [4];
        logic [6:0] seen [4];
        logic [6:0] want [4];
        want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int d = 0; d < 4; d++) begin lo[d] = 0; seen[d] = 'x; end
        bus_write(BASE, 32'h0000_1234);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL hex_scan cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            for (int d = 0; d < 4; d++)
                if (an[d] === 1'b0) begin lo[d]++; seen[d] = seg[6:0]; end
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (lo[d] !== 30) begin
                n_fail++; $display("FAIL hex_duty d%0d got %0d want 30", d, lo[d]);
            end
            n_checks++;
            if (seen[d] !== want[d]) begin
                n_fail++;
                $display("FAIL hex_pattern d%0d got %b want %b", d, seen[d], want[d]);
            end
        end
    endtask

    task automatic test_brightness();
        logic [11:0] e;
        int lo [4];
        int total;
        for (int d = 0; d < 4; d++) lo[d] = 0;
        bus_write(BASE + 2, 32'h0003_0000);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL bright3 cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            for (int d = 0; d < 4; d++) if (an[d] === 1'b0) lo[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (lo[d] !== 6) begin
                n_fail++; $display("FAIL bright3_duty d%0d got %0d want 6", d, lo[d]);
            end
        end
        total = 0;
        bus_write(BASE + 2, 32'h0000_0000);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL bright0 cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            if (an !== 4'hF) total++;
        end
        n_checks++;
        if (total !== 0) begin
            n_fail++; $display("FAIL bright0_dark got %0d lit cycles want 0", total);
        end
    endtask

    task automatic test_blank_dp();
        logic [11:0] e;
        int an1_lo, dp_bad;
        an1_lo = 0; dp_bad = 0;
        bus_write(BASE + 2, 32'h000F_0002);
        bus_write(BASE + 1, 32'h0000_0001);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL blank_dp cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            if (an[1] === 1'b0) an1_lo++;
            if ((seg[7] === 1'b0) != (an[0] === 1'b0)) dp_bad++;
        end
        n_checks++;
        if (an1_lo !== 0) begin
            n_fail++; $display("FAIL blank_an1 got %0d lit cycles want 0", an1_lo);
        end
        n_checks++;
        if (dp_bad !== 0) begin
            n_fail++; $display("FAIL dp_only_d0 got %0d bad cycles want 0", dp_bad);
        end
    endtask

    task automatic test_raw();
        logic [11:0] e;
        logic [6:0] seen2;
        seen2 = 'x;
        bus_write(BASE + 3, 32'h0000_027F);
        bus_write(BASE + 2, 32'h000F_0400);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL raw_d2 cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            if (an[2] === 1'b0) seen2 = seg[6:0];
        end
        n_checks++;
        if (seen2 !== 7'b0000000) begin
            n_fail++; $display("FAIL raw_d2_pattern got %b want 0000000", seen2);
        end
        bus_write(BASE + 3, 32'h0000_0555);
        bus_write(BASE + 2, 32'h000F_0F00);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL raw_idx5 cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [11:0] e;
        bus_write(BASE + 2, 32'h000F_0000);
        bus_write(BASE + 4, 32'hFFFF_FFFF);
        bus_write(BASE - 1, 32'hFFFF_FFFF);
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL out_of_range cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_readback();
        logic [31:0] a [4];
        logic [31:0] w [4];
        logic [31:0] r;
        bus_write(BASE, 32'h0000_ABCD);
        a = '{BASE, BASE + 4, BASE + 2, BASE + 3};
`ifdef SEG7_READBACK_EN
        w = '{32'h0000_ABCD, 32'h0, 32'h000F_0000, 32'h0000_027F};
`else
        w = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = 1'b1; rw = 1'b0; addr = a[i];
            rq.push_back(w[i]);
            @(negedge clk);
            enable = 1'b0;
            r = rq.pop_front();
            n_checks++;
            if (d_out !== r) begin
                n_fail++;
                $display("FAIL readback addr=%h got %h want %h", a[i], d_out, r);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        int waited;
        waited = 0;
        while (an !== 4'b1011 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (an !== 4'b1011) begin
            n_fail++; $display("FAIL mid_wait_d2 got %b want 1011", an);
        end
        #2 reset_n = 1'b0;
        reset_shadow();
        #1;
        n_checks++;
        if (seg !== 8'hFF) begin
            n_fail++; $display("FAIL mid_reset_seg got %h want ff", seg);
        end
        n_checks++;
        if (an !== 4'hF) begin
            n_fail++; $display("FAIL mid_reset_an got %b want 1111", an);
        end
        @(negedge clk);
        reset_n = 1'b1;
        push_expected(128);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL mid_restart cyc=%0d got %b/%h want %b/%h",
                         cyc, an, seg, e[11:8], e[7:0]);
            end
            if (i == 2) begin
                n_checks++;
                if (an !== 4'b1110) begin
                    n_fail++; $display("FAIL mid_first_lit got %b want 1110", an);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_brightness();
        test_blank_dp();
        test_raw();
        test_out_of_range();
        test_readback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_mux.md
Name: seg7_mux

Overview:
- Parametrised, memory-mapped multiplexed 7-segment display driver.
- Generalises the fixed 4-digit hex driver to 1..8 digits.
- Adds per-digit blanking, a per-digit raw-segment mode, global PWM brightness, an anti-ghosting guard interval, and optional register readback.
- Sits on the CPU peripheral bus and drives board segment/anode pins directly.

Parameters:
- BASE, 32'h10, first bus word address of the 4-word register window.
- NDIGITS, 4, number of digits; legal 1..8.
- PRESCALE, 1024, clk cycles per PWM tick; legal ≥2; counter width is $clog2(PRESCALE).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  bus cycle valid.
- rw  in  1  1 = write, 0 = read.
- addr  in  32  word address.
- data  in  32  write data.
- d_out  out  32  read data.
- seg  out  8  segments, active low; [0]=a..[6]=g, [7]=dp.
- an  out  NDIGITS  anodes, active low; an[0] is the rightmost digit.

Behaviour:
- Decode: in_range = addr ≥ BASE && addr < BASE+4. A write occurs when enable && rw && in_range.
- Register map (offset from BASE):
  - 0 DATA: bits [4*NDIGITS-1:0], hex nibble per digit; digit i = bits [4i+3:4i].
  - 1 DP: bits [NDIGITS-1:0]; 1 = decimal point lit.
  - 2 CTRL: [7:0] blank mask (1 = digit dark); [15:8] raw-mode mask; [19:16] BRIGHT.
  - 3 RAW: write data[10:8] = digit index, data[6:0] = pattern (1 = lit) stored to raw[idx]. Writes with idx ≥ NDIGITS are ignored.
  - Mask and pattern bits at or above NDIGITS are ignored.
- Reset values: DATA=0, DP=0, blank=0, raw mask=0, raw[*]=0, BRIGHT=15, counters=0, seg=8'hFF, an=all ones, d_out=0.
- Timing chain:
  - Prescale counter counts 0..PRESCALE-1 and emits tick on wrap.
  - 4-bit phase counter increments per tick.
  - On phase wrap 15→0, the digit index advances and wraps NDIGITS-1→0.
  - Slot length = 16*PRESCALE clk cycles; full frame = NDIGITS slots.
- Anode drive for current digit d:
  - an[d] is asserted (0) iff phase≠0 && phase ≤ BRIGHT && !blank[d]. All other anodes are 1.
  - Phase 0 is the guard interval: all anodes off.
  - BRIGHT=0 → display dark. BRIGHT=15 → 15/16 duty.
- Segment drive for current digit d:
  - If raw[d] mode: seg[6:0] = ~raw_pattern[d].
  - Otherwise: seg[6:0] = ~font(DATA nibble d), standard hex font 0-9, A, b, C, d, E, F.
  - seg[7] = ~DP[d].
  - When no anode is asserted, seg = 8'hFF.
- seg and an are registered: one clk latency from counter/register state to pins. A write at edge N is visible on the pins at edge N+1 if its digit is currently lit.
- Register writes never disturb the scan counters.
- Out-of-range addresses: no state change; d_out = 0.
- reset_n is asserted asynchronously mid-frame: outputs go to reset values immediately. Scanning restarts from digit 0, phase 0 after release.

Optional Feature:
- Macro: SEG7_READBACK_EN.
- Defined: on enable && !rw && in_range, d_out is registered (1-cycle latency) with the register contents.
  - Unused bits read 0.
  - RAW reads return {21'b0, last written idx[2:0], 1'b0, raw[last idx]}.
  - Otherwise d_out = 0.
- Undefined: d_out is tied to 0 and no read decode logic exists.

Test Plan:
- Reset, then write DATA=32'h0000_1234 with PRESCALE=2, NDIGITS=4 → over one frame (128 clk):
  - an cycles 1110, 1101, 1011, 0111.
  - seg[6:0] shows 4, 3, 2, 1 patterns (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001).
  - Anodes are off in each slot's first 2 cycles.
- CTRL BRIGHT=3 → each digit's anode is low for exactly 6 clk per 32-clk slot. BRIGHT=0 → an stays all ones for a full frame.
- Write CTRL blank=4'b0010 and DP=4'b0001 → an[1] never asserts; seg[7]=0 only while an[0]=0.
- Write RAW data=32'h0000_027F and CTRL raw mask=4'b0100 → digit 2 shows seg[6:0]=7'b0000000. A RAW write with idx 5 changes nothing.
- Assert reset_n low mid-slot 2 → seg=8'hFF and an=4'hF within the same cycle. After release, the first lit digit is digit 0 at clk 3 (PRESCALE=2).
- With SEG7_READBACK_EN, write DATA=32'hABCD then read offset 0 → d_out=32'h0000_ABCD one cycle later. A read at BASE+4 → 0.
